// File: rtl/regfile_wb_if.sv
// Writeback bus between the execute/memory stages, decode and the register-file write port.
// The arbiter takes the slave view; the pipeline (or bench) takes the master view.
interface regfile_wb_if #(
    parameter int DATA_W = 32
);
    logic              alu_valid;
    logic [4:0]        alu_rd;
    logic [DATA_W-1:0] alu_data;
    logic              alu_ready;
    logic              lsu_valid;
    logic [4:0]        lsu_rd;
    logic [DATA_W-1:0] lsu_data;
    logic              lsu_ready;
    logic              issue_en;
    logic [4:0]        issue_rd;
    logic [4:0]        rs1_add;
    logic [4:0]        rs2_add;
    logic              rs1_busy;
    logic              rs2_busy;
    logic              wd_en;
    logic [4:0]        wd_sel;
    logic [DATA_W-1:0] data;

    modport slave (
        input  alu_valid, alu_rd, alu_data, lsu_valid, lsu_rd, lsu_data,
        input  issue_en, issue_rd, rs1_add, rs2_add,
        output alu_ready, lsu_ready, rs1_busy, rs2_busy, wd_en, wd_sel, data
    );

    modport master (
        output alu_valid, alu_rd, alu_data, lsu_valid, lsu_rd, lsu_data,
        output issue_en, issue_rd, rs1_add, rs2_add,
        input  alu_ready, lsu_ready, rs1_busy, rs2_busy, wd_en, wd_sel, data
    );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter of ALU and LSU writebacks onto the single register-file write port,
// with a pending-write scoreboard that decode uses to stall on read-after-write hazards.
module regfile_wb_arbiter #(
    parameter int DATA_W = 32,
    parameter int NREG   = 32
) (
    input  logic         clk,
    input  logic         rst,
    regfile_wb_if.slave  wb
);
    typedef enum logic {
        SRC_ALU = 1'b0,
        SRC_LSU = 1'b1
    } src_e;

    src_e              last_r;
    logic              wd_en_r;
    logic [4:0]        wd_sel_r;
    logic [DATA_W-1:0] data_r;
    logic [NREG-1:0]   pending_r;
    logic [NREG-1:0]   pending_nxt_s;
    logic              alu_gnt_s;
    logic              lsu_gnt_s;

    // x0 and indices beyond the implemented registers never report a pending write.
    function automatic logic busy_of(input logic [NREG-1:0] pend, input logic [4:0] idx);
        logic res;
        if (idx == 5'd0) begin
            res = 1'b0;
        end else if (32'(idx) < 32'(NREG)) begin
            res = pend[idx];
        end else begin
            res = 1'b0;
        end
        return res;
    endfunction

    // Grant selection: single requester wins outright, a conflict goes to the source not named by last.
    always_comb begin
        alu_gnt_s = 1'b0;
        lsu_gnt_s = 1'b0;
        if (rst) begin
            alu_gnt_s = 1'b0;
            lsu_gnt_s = 1'b0;
        end else if (wb.alu_valid && wb.lsu_valid) begin
            if (last_r == SRC_LSU) begin
                alu_gnt_s = 1'b1;
            end else begin
                lsu_gnt_s = 1'b1;
            end
        end else if (wb.alu_valid) begin
            alu_gnt_s = 1'b1;
        end else if (wb.lsu_valid) begin
            lsu_gnt_s = 1'b1;
        end else begin
            alu_gnt_s = 1'b0;
            lsu_gnt_s = 1'b0;
        end
    end

    // Scoreboard next state: clear on the committed write, then set on issue so a new producer wins.
    always_comb begin
        pending_nxt_s = pending_r;
        if (wd_en_r && (32'(wd_sel_r) < 32'(NREG))) begin
            pending_nxt_s[wd_sel_r] = 1'b0;
        end else begin
            pending_nxt_s = pending_nxt_s;
        end
        if (wb.issue_en && (wb.issue_rd != 5'd0) && (32'(wb.issue_rd) < 32'(NREG))) begin
            pending_nxt_s[wb.issue_rd] = 1'b1;
        end else begin
            pending_nxt_s = pending_nxt_s;
        end
    end

    // Registered write-port stage, round-robin pointer and scoreboard.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_r    <= SRC_LSU;
            wd_en_r   <= 1'b0;
            wd_sel_r  <= 5'd0;
            data_r    <= '0;
            pending_r <= '0;
        end else begin
            pending_r <= pending_nxt_s;
            if (wb.alu_valid && wb.lsu_valid) begin
                last_r <= alu_gnt_s ? SRC_ALU : SRC_LSU;
            end else begin
                last_r <= last_r;
            end
            if (alu_gnt_s) begin
                wd_en_r  <= (wb.alu_rd != 5'd0);
                wd_sel_r <= wb.alu_rd;
                data_r   <= wb.alu_data;
            end else if (lsu_gnt_s) begin
                wd_en_r  <= (wb.lsu_rd != 5'd0);
                wd_sel_r <= wb.lsu_rd;
                data_r   <= wb.lsu_data;
            end else begin
                wd_en_r  <= 1'b0;
                wd_sel_r <= wd_sel_r;
                data_r   <= data_r;
            end
        end
    end

    assign wb.alu_ready = alu_gnt_s;
    assign wb.lsu_ready = lsu_gnt_s;
    assign wb.wd_en     = wd_en_r;
    assign wb.wd_sel    = wd_sel_r;
    assign wb.data      = data_r;
    assign wb.rs1_busy  = busy_of(pending_r, wb.rs1_add);
    assign wb.rs2_busy  = busy_of(pending_r, wb.rs2_add);
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: a vector table of writeback requests with a one-cycle-latency
// expectation queue, followed by hand-written scoreboard, x0 and reset sequences.
module tb_regfile_wb_arbiter;
    logic clk;
    logic rst;
    logic waw_bypass;
    logic [31:0] mon_pend;
    int checks;
    int errors;

    regfile_wb_if #(.DATA_W(32)) wb ();

    regfile_wb_arbiter #(.DATA_W(32), .NREG(32)) dut (
        .clk (clk),
        .rst (rst),
        .wb  (wb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        av;
        logic [4:0]  ard;
        logic [31:0] adat;
        logic        lv;
        logic [4:0]  lrd;
        logic [31:0] ldat;
        logic        e_ar;
        logic        e_lr;
        logic        e_en;
        logic [4:0]  e_sel;
        logic [31:0] e_dat;
    } vec_t;

    typedef struct {
        logic        en;
        logic [4:0]  sel;
        logic [31:0] dat;
    } wd_exp_t;

    localparam int NV = 13;
    vec_t    vecs [NV];
    wd_exp_t sb [$];

    function automatic vec_t mk(input logic av, input logic [4:0] ard, input logic [31:0] adat,
                                input logic lv, input logic [4:0] lrd, input logic [31:0] ldat,
                                input logic e_ar, input logic e_lr, input logic e_en,
                                input logic [4:0] e_sel, input logic [31:0] e_dat);
        vec_t v;
        v.av = av; v.ard = ard; v.adat = adat;
        v.lv = lv; v.lrd = lrd; v.ldat = ldat;
        v.e_ar = e_ar; v.e_lr = e_lr; v.e_en = e_en; v.e_sel = e_sel; v.e_dat = e_dat;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Protocol monitor: decode must never issue to a register with an outstanding write.
    always @(posedge clk) begin
        if (rst) begin
            mon_pend <= 32'd0;
        end else begin
            if (wb.issue_en && !waw_bypass) begin
                assert (!mon_pend[wb.issue_rd])
                    else $error("FAIL waw: issue to pending register %0d", wb.issue_rd);
            end
            mon_pend <= (mon_pend & ~((wb.wd_en ? 32'd1 : 32'd0) << wb.wd_sel))
                        | ((wb.issue_en && wb.issue_rd != 5'd0) ? (32'd1 << wb.issue_rd) : 32'd0);
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        wd_exp_t e;
        checks = 0;
        errors = 0;
        waw_bypass = 1'b0;
        rst = 1'b1;
        wb.alu_valid = 1'b1; wb.alu_rd = 5'd3; wb.alu_data = 32'h0000_0001;
        wb.lsu_valid = 1'b1; wb.lsu_rd = 5'd4; wb.lsu_data = 32'h0000_0002;
        wb.issue_en = 1'b0; wb.issue_rd = 5'd0; wb.rs1_add = 5'd3; wb.rs2_add = 5'd4;

        // Vectors: last starts at LSU; expected write-port values appear one cycle after the grant.
        vecs[0]  = mk(1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, 5'd0, 32'h0,         1'b1, 1'b0, 1'b1, 5'd5,  32'hDEAD_BEEF);
        vecs[1]  = mk(1'b0, 5'd0, 32'h0,         1'b0, 5'd0, 32'h0,         1'b0, 1'b0, 1'b0, 5'd5,  32'hDEAD_BEEF);
        vecs[2]  = mk(1'b1, 5'd1, 32'h1111_1111, 1'b1, 5'd2, 32'h2222_2222, 1'b1, 1'b0, 1'b1, 5'd1,  32'h1111_1111);
        vecs[3]  = mk(1'b1, 5'd1, 32'h1111_1111, 1'b1, 5'd2, 32'h2222_2222, 1'b0, 1'b1, 1'b1, 5'd2,  32'h2222_2222);
        vecs[4]  = mk(1'b1, 5'd1, 32'h1111_1111, 1'b1, 5'd2, 32'h2222_2222, 1'b1, 1'b0, 1'b1, 5'd1,  32'h1111_1111);
        vecs[5]  = mk(1'b1, 5'd1, 32'h1111_1111, 1'b1, 5'd2, 32'h2222_2222, 1'b0, 1'b1, 1'b1, 5'd2,  32'h2222_2222);
        vecs[6]  = mk(1'b0, 5'd0, 32'h0,         1'b1, 5'd0, 32'h0000_1234, 1'b0, 1'b1, 1'b0, 5'd0,  32'h0000_1234);
        vecs[7]  = mk(1'b0, 5'd0, 32'h0,         1'b1, 5'd3, 32'hCAFE_F00D, 1'b0, 1'b1, 1'b1, 5'd3,  32'hCAFE_F00D);
        vecs[8]  = mk(1'b1, 5'd4, 32'hA5A5_A5A5, 1'b1, 5'd6, 32'h5A5A_5A5A, 1'b1, 1'b0, 1'b1, 5'd4,  32'hA5A5_A5A5);
        vecs[9]  = mk(1'b0, 5'd0, 32'h0,         1'b1, 5'd6, 32'h5A5A_5A5A, 1'b0, 1'b1, 1'b1, 5'd6,  32'h5A5A_5A5A);
        vecs[10] = mk(1'b1, 5'd8, 32'h0BAD_C0DE, 1'b1, 5'd10, 32'h1010_1010, 1'b0, 1'b1, 1'b1, 5'd10, 32'h1010_1010);
        vecs[11] = mk(1'b1, 5'd8, 32'h0BAD_C0DE, 1'b0, 5'd0, 32'h0,         1'b1, 1'b0, 1'b1, 5'd8,  32'h0BAD_C0DE);
        vecs[12] = mk(1'b0, 5'd0, 32'h0,         1'b0, 5'd0, 32'h0,         1'b0, 1'b0, 1'b0, 5'd8,  32'h0BAD_C0DE);

        // Reset held two cycles with both requesters valid.
        for (int r = 0; r < 2; r++) begin
            @(negedge clk);
            check("rst_alu_ready", 32'(wb.alu_ready), 32'd0);
            check("rst_lsu_ready", 32'(wb.lsu_ready), 32'd0);
            @(posedge clk); #1;
            check("rst_wd_en", 32'(wb.wd_en), 32'd0);
            check("rst_wd_sel", 32'(wb.wd_sel), 32'd0);
            check("rst_data", wb.data, 32'd0);
            check("rst_rs1_busy", 32'(wb.rs1_busy), 32'd0);
        end
        @(negedge clk);
        rst = 1'b0;
        wb.alu_valid = 1'b0; wb.lsu_valid = 1'b0; wb.rs1_add = 5'd0; wb.rs2_add = 5'd0;

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            wb.alu_valid = vecs[i].av; wb.alu_rd = vecs[i].ard; wb.alu_data = vecs[i].adat;
            wb.lsu_valid = vecs[i].lv; wb.lsu_rd = vecs[i].lrd; wb.lsu_data = vecs[i].ldat;
            #1;
            check($sformatf("v%0d_alu_ready", i), 32'(wb.alu_ready), 32'(vecs[i].e_ar));
            check($sformatf("v%0d_lsu_ready", i), 32'(wb.lsu_ready), 32'(vecs[i].e_lr));
            e.en = vecs[i].e_en; e.sel = vecs[i].e_sel; e.dat = vecs[i].e_dat;
            sb.push_back(e);
            @(posedge clk); #1;
            e = sb.pop_front();
            check($sformatf("v%0d_wd_en", i), 32'(wb.wd_en), 32'(e.en));
            check($sformatf("v%0d_wd_sel", i), 32'(wb.wd_sel), 32'(e.sel));
            check($sformatf("v%0d_data", i), wb.data, e.dat);
        end

        // Scoreboard lifecycle on register 7.
        @(negedge clk);
        wb.alu_valid = 1'b0; wb.lsu_valid = 1'b0;
        wb.issue_en = 1'b1; wb.issue_rd = 5'd7; wb.rs1_add = 5'd7;
        #1 check("sb_busy_before_issue", 32'(wb.rs1_busy), 32'd0);
        @(posedge clk); #1;
        check("sb_busy_after_issue", 32'(wb.rs1_busy), 32'd1);
        @(negedge clk);
        wb.issue_en = 1'b0;
        wb.alu_valid = 1'b1; wb.alu_rd = 5'd7; wb.alu_data = 32'h0000_0077;
        #1 check("sb_alu_ready", 32'(wb.alu_ready), 32'd1);
        check("sb_busy_grant_cycle", 32'(wb.rs1_busy), 32'd1);
        @(posedge clk); #1;
        check("sb_wd_en", 32'(wb.wd_en), 32'd1);
        check("sb_wd_sel", 32'(wb.wd_sel), 32'd7);
        check("sb_busy_wd_cycle", 32'(wb.rs1_busy), 32'd1);
        @(negedge clk);
        wb.alu_valid = 1'b0;
        @(posedge clk); #1;
        check("sb_wd_en_after", 32'(wb.wd_en), 32'd0);
        check("sb_busy_cleared", 32'(wb.rs1_busy), 32'd0);

        // Issuing to x0 never marks anything pending.
        @(negedge clk);
        wb.issue_en = 1'b1; wb.issue_rd = 5'd0; wb.rs1_add = 5'd0;
        @(posedge clk); #1;
        check("x0_issue_busy", 32'(wb.rs1_busy), 32'd0);

        // Register 9: a new issue on the very edge its write commits keeps it busy.
        @(negedge clk);
        wb.issue_en = 1'b1; wb.issue_rd = 5'd9; wb.rs2_add = 5'd9;
        @(posedge clk); #1;
        check("sc_busy_set", 32'(wb.rs2_busy), 32'd1);
        @(negedge clk);
        wb.issue_en = 1'b0;
        wb.alu_valid = 1'b1; wb.alu_rd = 5'd9; wb.alu_data = 32'h0000_0099;
        @(posedge clk); #1;
        check("sc_wd_en", 32'(wb.wd_en), 32'd1);
        check("sc_wd_sel", 32'(wb.wd_sel), 32'd9);
        @(negedge clk);
        wb.alu_valid = 1'b0;
        waw_bypass = 1'b1;
        wb.issue_en = 1'b1; wb.issue_rd = 5'd9;
        @(posedge clk); #1;
        check("sc_busy_set_wins", 32'(wb.rs2_busy), 32'd1);
        @(negedge clk);
        wb.issue_en = 1'b0;
        waw_bypass = 1'b0;
        @(posedge clk); #1;
        check("sc_busy_held", 32'(wb.rs2_busy), 32'd1);

        // Mid-stream reset drops the in-flight write and all pending bits.
        @(negedge clk);
        wb.issue_en = 1'b1; wb.issue_rd = 5'd12; wb.rs1_add = 5'd12;
        wb.alu_valid = 1'b1; wb.alu_rd = 5'd12; wb.alu_data = 32'h0000_0C0C;
        wb.lsu_valid = 1'b1; wb.lsu_rd = 5'd13; wb.lsu_data = 32'h0000_0D0D;
        @(posedge clk); #1;
        check("mr_busy_before", 32'(wb.rs1_busy), 32'd1);
        check("mr_wd_en_before", 32'(wb.wd_en), 32'd1);
        @(negedge clk);
        wb.issue_en = 1'b0;
        rst = 1'b1;
        #1 check("mr_alu_ready", 32'(wb.alu_ready), 32'd0);
        check("mr_lsu_ready", 32'(wb.lsu_ready), 32'd0);
        @(posedge clk); #1;
        check("mr_rs1_busy", 32'(wb.rs1_busy), 32'd0);
        check("mr_rs2_busy", 32'(wb.rs2_busy), 32'd0);
        check("mr_wd_en", 32'(wb.wd_en), 32'd0);
        check("mr_wd_sel", 32'(wb.wd_sel), 32'd0);
        check("mr_data", wb.data, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        wb.alu_valid = 1'b0; wb.lsu_valid = 1'b0;
        repeat (2) @(posedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
